// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM path scheduler and its round-robin arbiter.
// Pure declarations: no timing, no flow control.
package tdm_pkg;

  localparam int NUM_SRC = 4;
  localparam int SEL_W = 2;
  localparam logic [7:0] ROUTE_RESET = 8'hE4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACTIVE,
    GUARD
  } state_t;

  function automatic logic [NUM_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_SRC-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin pick starting just after the previous winner.
// Combinational, zero latency; no backpressure.
module rr_arbiter4
  import tdm_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   winner,
  output logic               found
);

  // Walk from farthest to nearest so the source right after 'last' wins.
  always_comb begin
    winner = last;
    found  = 1'b0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      if (req[last + SEL_W'(i)]) begin
        winner = last + SEL_W'(i);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdm_path_scheduler.sv
// Round-robin TDM scheduler for the 4:1 mux / 1:4 demux path; grant outputs one cycle after arbitration,
// path_en for SLOT_LEN cycles per grant, bracketed by setup/guard cycles; no backpressure beyond req level.
module tdm_path_scheduler
  import tdm_pkg::*;
#(
  parameter int unsigned SLOT_LEN  = 4,
  parameter bit          EARLY_REL = 1'b1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       cfg_we,
  input  logic [7:0] cfg_route,
  output logic [1:0] mux_sel,
  output logic [1:0] demux_sel,
  output logic       path_en,
  output logic [3:0] gnt,
  output logic       slot_done,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_LEN - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       route_q, route_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       mux_sel_q, mux_sel_d;
  logic [1:0]       demux_sel_q, demux_sel_d;
  logic             path_en_q, path_en_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             slot_done_q, slot_done_d;
  logic             busy_q, busy_d;
  logic [1:0]       arb_winner;
  logic             arb_found;

  rr_arbiter4 u_arb (
    .req    (req),
    .last   (last_q),
    .winner (arb_winner),
    .found  (arb_found)
  );

  // Outputs are decoded from the current state and registered, so they trail the state by one cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    route_d     = route_q;
    last_d      = last_q;
    mux_sel_d   = mux_sel_q;
    demux_sel_d = demux_sel_q;
    path_en_d   = 1'b0;
    gnt_d       = '0;
    slot_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_we) begin
          route_d = cfg_route;
        end else if (arb_found) begin
          last_d  = arb_winner;
          state_d = SETUP;
        end
      end
      SETUP: begin
        mux_sel_d   = last_q;
        demux_sel_d = route_q[{last_q, 1'b0} +: SEL_W];
        gnt_d       = onehot(last_q);
        cnt_d       = '0;
        state_d     = ACTIVE;
      end
      ACTIVE: begin
        path_en_d = 1'b1;
        gnt_d     = onehot(last_q);
        if (cnt_q == CNT_LAST || (EARLY_REL && !req[last_q])) begin
          state_d = GUARD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GUARD: begin
        slot_done_d = 1'b1;
        if (arb_found) begin
          last_d  = arb_winner;
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      route_q     <= ROUTE_RESET;
      last_q      <= 2'd3;
      mux_sel_q   <= '0;
      demux_sel_q <= '0;
      path_en_q   <= 1'b0;
      gnt_q       <= '0;
      slot_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      route_q     <= route_d;
      last_q      <= last_d;
      mux_sel_q   <= mux_sel_d;
      demux_sel_q <= demux_sel_d;
      path_en_q   <= path_en_d;
      gnt_q       <= gnt_d;
      slot_done_q <= slot_done_d;
      busy_q      <= busy_d;
    end
  end

  assign mux_sel   = mux_sel_q;
  assign demux_sel = demux_sel_q;
  assign path_en   = path_en_q;
  assign gnt       = gnt_q;
  assign slot_done = slot_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_tdm_path_scheduler.sv
// Bench for tdm_path_scheduler: an early-release instance and a full-slot instance share stimulus,
// each is compared every cycle against a slot-level reference model, plus directed latency checks.
module tb_tdm_path_scheduler;

  localparam int L = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = '0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_route = '0;
  logic [1:0] mux_sel, demux_sel, mux_sel0, demux_sel0;
  logic       path_en, slot_done, busy, path_en0, slot_done0, busy0;
  logic [3:0] gnt, gnt0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  tdm_path_scheduler #(.SLOT_LEN(L), .EARLY_REL(1'b1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .cfg_we(cfg_we), .cfg_route(cfg_route),
    .mux_sel(mux_sel), .demux_sel(demux_sel), .path_en(path_en), .gnt(gnt),
    .slot_done(slot_done), .busy(busy)
  );

  tdm_path_scheduler #(.SLOT_LEN(L), .EARLY_REL(1'b0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .cfg_we(cfg_we), .cfg_route(cfg_route),
    .mux_sel(mux_sel0), .demux_sel(demux_sel0), .path_en(path_en0), .gnt(gnt0),
    .slot_done(slot_done0), .busy(busy0)
  );

  // Reference model, one per instance: a slot in progress is described by its source,
  // its age (0 = settle cycle, 1..L = enabled cycles) and whether it is in its closing cycle.
  bit         m_busy[2], m_closing[2];
  int         m_src[2], m_age[2], m_last[2];
  logic [7:0] m_route[2];
  int         e_mux[2], e_demux[2], e_gnt[2];
  bit         e_pe[2], e_sd[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_closing[k] = 0; m_src[k] = 0; m_age[k] = 0;
      m_last[k] = 3; m_route[k] = 8'hE4;
      e_mux[k] = 0; e_demux[k] = 0; e_gnt[k] = 0; e_pe[k] = 0; e_sd[k] = 0;
    end
  endtask

  task automatic model_edge(input int k, input bit early);
    logic [7:0] sh;
    int w;
    e_pe[k] = 0; e_gnt[k] = 0; e_sd[k] = 0;
    if (m_busy[k] && m_closing[k]) begin
      e_sd[k] = 1;
    end else if (m_busy[k]) begin
      e_gnt[k] = 1 << m_src[k];
      if (m_age[k] == 0) begin
        sh = m_route[k] >> (2 * m_src[k]);
        e_mux[k] = m_src[k];
        e_demux[k] = int'(sh[1:0]);
      end else begin
        e_pe[k] = 1;
      end
    end
    if (!m_busy[k] && cfg_we) begin
      m_route[k] = cfg_route;
    end else if (!m_busy[k] || m_closing[k]) begin
      w = rr_pick(m_last[k], req);
      m_closing[k] = 0;
      m_busy[k] = (w >= 0);
      if (w >= 0) begin
        m_src[k] = w; m_last[k] = w; m_age[k] = 0;
      end
    end else if (m_age[k] == L || (m_age[k] > 0 && early && !req[m_src[k]])) begin
      m_closing[k] = 1;
    end else begin
      m_age[k]++;
    end
  endtask

  task automatic check_out(input int k, input logic [1:0] mx, input logic [1:0] dm, input logic pe,
                           input logic [3:0] g, input logic sd, input logic b);
    chk($sformatf("i%0d.mux_sel", k), 32'(mx), e_mux[k]);
    chk($sformatf("i%0d.demux_sel", k), 32'(dm), e_demux[k]);
    chk($sformatf("i%0d.path_en", k), 32'(pe), 32'(e_pe[k]));
    chk($sformatf("i%0d.gnt", k), 32'(g), e_gnt[k]);
    chk($sformatf("i%0d.slot_done", k), 32'(sd), 32'(e_sd[k]));
    chk($sformatf("i%0d.busy", k), 32'(b), 32'(m_busy[k]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0, 1'b1);
    model_edge(1, 1'b0);
    cyc++;
    #1;
    check_out(0, mux_sel, demux_sel, path_en, gnt, slot_done, busy);
    check_out(1, mux_sel0, demux_sel0, path_en0, gnt0, slot_done0, busy0);
  endtask

  // Called shortly after a clock edge; reset is asserted and released between edges.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst.path_en", 32'(path_en), 0);
    chk("rst.gnt", 32'(gnt), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.slot_done", 32'(slot_done), 0);
    chk("rst.mux_sel", 32'(mux_sel), 0);
    chk("rst.demux_sel", 32'(demux_sel), 0);
    chk("rst.path_en0", 32'(path_en0), 0);
    chk("rst.gnt0", 32'(gnt0), 0);
    chk("rst.busy0", 32'(busy0), 0);
    model_reset();
    #2 rst_n = 1'b1;
  endtask

  task automatic go_idle();
    req = '0;
    cfg_we = 1'b0;
    repeat (8) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen, last_cyc, idx, pe_a, pe_b;
    bit hit;
    model_reset();
    #1;
    do_reset();

    // Single requester: latency, slot length, guard pulse, re-grant.
    req = 4'b0100;
    step();
    step();
    chk("t1.gnt", 32'(gnt), 32'h4);
    chk("t1.mux_sel", 32'(mux_sel), 2);
    chk("t1.demux_sel", 32'(demux_sel), 2);
    chk("t1.path_en_setup", 32'(path_en), 0);
    for (int i = 0; i < L; i++) begin
      step();
      chk($sformatf("t1.path_en_%0d", i), 32'(path_en), 1);
    end
    step();
    chk("t1.path_en_guard", 32'(path_en), 0);
    chk("t1.slot_done", 32'(slot_done), 1);
    step();
    chk("t1.regrant", 32'(gnt), 32'h4);

    // All four requesting from reset: order 0,1,2,3,0 with a period of L+2.
    do_reset();
    req = 4'b1111;
    seen = 0;
    last_cyc = 0;
    hit = 0;
    for (int i = 0; i < 40 && seen < 5; i++) begin
      step();
      if (gnt != 0 && !hit) begin
        idx = 0;
        for (int b = 0; b < 4; b++) if (gnt[b]) idx = b;
        chk("rr.order", 32'(idx), 32'(seen % 4));
        if (seen > 0) chk("rr.period", 32'(cyc - last_cyc), L + 2);
        last_cyc = cyc;
        seen++;
      end
      hit = (gnt != 0);
    end
    chk("rr.grants", 32'(seen), 5);

    // Route write while a slot is active must be ignored.
    go_idle();
    req = 4'b0010;
    repeat (3) step();
    cfg_we = 1'b1;
    cfg_route = 8'h00;
    step();
    cfg_we = 1'b0;
    req = 4'b1000;
    hit = 0;
    for (int i = 0; i < 12 && !hit; i++) begin
      step();
      hit = (gnt == 4'b1000);
    end
    chk("cfgact.reached", 32'(hit), 1);
    chk("cfgact.mux_sel", 32'(mux_sel), 3);
    chk("cfgact.demux_sel", 32'(demux_sel), 3);

    // Route write in IDLE defers arbitration by one cycle and applies the new map.
    go_idle();
    cfg_we = 1'b1;
    cfg_route = 8'h1B;
    req = 4'b0001;
    step();
    chk("cfgidle.defer_busy", 32'(busy), 0);
    cfg_we = 1'b0;
    step();
    step();
    chk("cfgidle.gnt", 32'(gnt), 1);
    chk("cfgidle.mux_sel", 32'(mux_sel), 0);
    chk("cfgidle.demux_sel", 32'(demux_sel), 3);

    // Requester drops after two enabled cycles: early release vs full slot.
    go_idle();
    req = 4'b0010;
    step();
    pe_a = 0;
    pe_b = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      pe_a += int'(path_en);
      pe_b += int'(path_en0);
      if (i == 1) req = 4'b0000;
    end
    chk("early.pe_cycles", 32'(pe_a), 2);
    chk("full.pe_cycles", 32'(pe_b), L);

    // Reset in the middle of a slot, then first grant goes to the lowest requester.
    go_idle();
    req = 4'b1000;
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      step();
      hit = path_en;
    end
    chk("midrst.reached_active", 32'(hit), 1);
    do_reset();
    req = 4'b1010;
    step();
    step();
    chk("midrst.first_gnt", 32'(gnt), 32'h2);

    // Randomised traffic with occasional route writes and resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      cfg_we = ($urandom_range(0, 15) == 0);
      cfg_route = 8'($urandom);
      if ($urandom_range(0, 149) == 0) do_reset();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdm_path_scheduler.md
Name: tdm_path_scheduler

Overview:
- Time-division scheduler for the 4:1 mux / 1:4 demux path pair (int_mux + int_demux).
- Shares the single serial path among four requesting sources using round-robin arbitration.
- For each granted source it drives the mux select, the demux select (from a programmable route map) and the common path enable.
- Each grant is held for a fixed slot length and is bracketed by one-cycle setup and guard phases, so selects never change while the enable is high.

Parameters:
- SLOT_LEN, 4, number of cycles path_en stays high per grant (legal range 1..255).
- EARLY_REL, 1, when 1 a granted source dropping its req ends its slot early; when 0 the full slot always runs.
- CNT_W, 8, width of the slot counter (localparam-sized; must hold SLOT_LEN-1).

Ports:
- clk        input   1  rising-edge clock
- rst_n      input   1  asynchronous active-low reset
- req        input   4  per-source request, level-sensitive; bit i = source i
- cfg_we     input   1  route-map write strobe
- cfg_route  input   8  route map; bits [2i+1:2i] = demux output for source i
- mux_sel    output  2  to mux s: selected source index
- demux_sel  output  2  to demux t: destination for the selected source
- path_en    output  1  to mux/demux e: path enable
- gnt        output  4  one-hot grant; all zero when no grant is active
- slot_done  output  1  one-cycle pulse when a slot ends (normal or early)
- busy       output  1  high whenever state != IDLE

Behaviour:
- Reset is asynchronous, active-low, single clock domain.
- Reset values: state=IDLE, mux_sel=0, demux_sel=0, path_en=0, gnt=0, slot_done=0, busy=0, route_reg=8'hE4 (identity: source i to output i), rr_last=3 (first search starts at source 0), counter=0.
- All outputs are registered.
- States: IDLE, SETUP, ACTIVE, GUARD.
- IDLE:
  - cfg_we=1: write route_reg<=cfg_route and stay in IDLE, even if req!=0. Arbitration is deferred one cycle so the new map is used.
  - Otherwise, if req!=0: select the first set bit searching (rr_last+1) mod 4 upward with wrap; set rr_last<=winner; go to SETUP.
- SETUP (exactly 1 cycle):
  - mux_sel=winner, demux_sel=route_reg[2w+1:2w], gnt=one-hot(winner), path_en=0.
  - This is the select-settle cycle. Then go to ACTIVE with counter=0.
- ACTIVE:
  - path_en=1; mux_sel, demux_sel and gnt held; counter increments each cycle.
  - Leave to GUARD when counter==SLOT_LEN-1.
  - Also leave to GUARD when EARLY_REL=1 and req[winner]=0 is sampled; that is the last path_en cycle.
- GUARD (exactly 1 cycle):
  - path_en=0, gnt=0, slot_done=1; mux_sel and demux_sel keep their last values.
  - Arbitrate exactly as in IDLE: req!=0 goes to SETUP, else IDLE.
  - cfg_we in GUARD is ignored.
- cfg_we is ignored in every state except IDLE; there is no queueing.
- Latency: req first sampled in IDLE at edge n gives gnt, mux_sel and demux_sel valid after edge n+1. path_en is high after edges n+2 .. n+1+SLOT_LEN. slot_done is high after edge n+2+SLOT_LEN.
- Back-to-back slot period: SLOT_LEN+2 cycles.
- All four requesting continuously: grant order 0,1,2,3,0,...
- Source dropping req in SETUP: its slot still proceeds. With EARLY_REL=1 the slot ends after one ACTIVE cycle.
- Requests arriving mid-slot are not registered separately; arbitration uses the req level sampled in IDLE or GUARD.
- Reset mid-slot: all outputs return to reset values immediately (path_en drops with no guard cycle); route_reg returns to 8'hE4.
- Invariants:
  - path_en=1 implies gnt!=0.
  - At most one gnt bit set.
  - mux_sel and demux_sel never change on a cycle where path_en is 1 before and after.

Decomposition:
- Shared package tdm_pkg:
  - state enum (IDLE, SETUP, ACTIVE, GUARD)
  - ROUTE_RESET=8'hE4
  - NUM_SRC=4
  - SEL_W=2
- Sub-module rr_arbiter4:
  - inputs req[3:0], last[1:0]
  - outputs winner[1:0], found
  - purely combinational
- The FSM, counter and route register stay in the top-level module.

Test Plan:
- Reset then req=4'b0100 held, SLOT_LEN=4 → edge n+1: gnt=4'b0100, mux_sel=2, demux_sel=2, path_en=0. path_en=1 for 4 cycles. slot_done pulse. Next SETUP re-grants source 2.
- req=4'b1111 held → grant sequence 0,1,2,3,0; each path_en window 4 cycles; 6-cycle period; path_en=0 between windows.
- In IDLE: cfg_we=1 with cfg_route=8'h1B and req=4'b0001 in the same cycle → one extra IDLE cycle, then mux_sel=0, demux_sel=3.
- cfg_we pulse during ACTIVE with cfg_route=8'h00 → ignored; next source still routed via 8'hE4.
- EARLY_REL=1: req[1] dropped after 2 ACTIVE cycles → path_en high 2 cycles then GUARD with slot_done=1. With EARLY_REL=0 → full 4 cycles.
- rst_n asserted low mid-ACTIVE → path_en, gnt and busy go to 0 immediately without a clock edge. After release, the first grant goes to the lowest-index requester.
